// File: rtl/layer_seq_pkg.sv
// Shared types and width helpers for the layer sequencer.
package layer_seq_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        BCAST = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    // Default block parameters and the widths derived from them.
    localparam int unsigned DefNumInputs    = 784;
    localparam int unsigned DefNumNeurons   = 30;
    localparam int unsigned DefDataWidth    = 16;
    localparam int unsigned DefTimeoutCycles = 64;

    // Counter able to hold every value 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Address width for a memory of the given depth (never zero).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned DefInCntW  = cnt_width(DefNumInputs);
    localparam int unsigned DefNrnCntW = cnt_width(DefNumNeurons);
    localparam int unsigned DefToCntW  = cnt_width(DefTimeoutCycles);
    localparam int unsigned DefAddrW   = addr_width(DefNumInputs);

endpackage

// File: rtl/layer_sequencer_seq_buf.sv
// Simple dual-port RAM: synchronous write, registered one-cycle read.
module seq_buf #(
    parameter int unsigned Depth = 784,
    parameter int unsigned Width = 16,
    parameter int unsigned AddrW = 10
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully connected layer: buffer input vector, broadcast it to
// all neurons as one gap-free burst, collect activations, stream them out.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int unsigned NUM_INPUTS     = DefNumInputs,
    parameter int unsigned NUM_NEURONS    = DefNumNeurons,
    parameter int unsigned DATA_WIDTH     = DefDataWidth,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [DATA_WIDTH-1:0]             nrn_in_data,
    output logic                              nrn_in_valid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out_data,
    input  logic [NUM_NEURONS-1:0]            nrn_out_valid,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              busy,
    output logic                              err_timeout
);

    localparam int unsigned InCntW  = cnt_width(NUM_INPUTS);
    localparam int unsigned NrnCntW = cnt_width(NUM_NEURONS);
    localparam int unsigned ToCntW  = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned AddrW   = addr_width(NUM_INPUTS);

    localparam logic [InCntW-1:0]  InLast  = InCntW'(NUM_INPUTS - 1);
    localparam logic [InCntW-1:0]  InEnd   = InCntW'(NUM_INPUTS);
    localparam logic [NrnCntW-1:0] NrnLast = NrnCntW'(NUM_NEURONS - 1);
    localparam logic [ToCntW-1:0]  ToLast  = ToCntW'(TIMEOUT_CYCLES - 1);

    seq_state_t                  state_q, state_d;
    logic [InCntW-1:0]           wr_cnt_q, wr_cnt_d;
    logic [InCntW-1:0]           rd_cnt_q, rd_cnt_d;
    logic [NrnCntW-1:0]          rd_idx_q, rd_idx_d;
    logic [ToCntW-1:0]           to_cnt_q, to_cnt_d;
    logic [NUM_NEURONS-1:0]      mask_q, mask_d;
    logic                        err_q, err_d;
    logic                        rd_vld_q;
    logic                        nrn_vld_q;
    logic [DATA_WIDTH-1:0]       nrn_data_q;
    logic [DATA_WIDTH-1:0]       out_buf_q [NUM_NEURONS];

    logic                        buf_we, buf_re;
    logic [DATA_WIDTH-1:0]       buf_rdata;
    logic [NUM_NEURONS-1:0]      cap_en, zero_en;
    logic [DATA_WIDTH-1:0]       out_sel;
    logic                        in_xfer, out_xfer;

    assign in_ready  = rst & (state_q == FILL);
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid & (rd_idx_q == NrnLast);
    assign out_xfer  = out_valid & out_ready;
    assign out_data  = out_valid ? out_sel : '0;
    assign busy      = (state_q != FILL);
    assign err_timeout  = err_q;
    assign nrn_in_valid = nrn_vld_q;
    assign nrn_in_data  = nrn_data_q;

    seq_buf #(
        .Depth (NUM_INPUTS),
        .Width (DATA_WIDTH),
        .AddrW (AddrW)
    ) u_in_buf (
        .clk_i   (clk),
        .we_i    (buf_we),
        .waddr_i (wr_cnt_q[AddrW-1:0]),
        .wdata_i (in_data),
        .re_i    (buf_re),
        .raddr_i (rd_cnt_q[AddrW-1:0]),
        .rdata_o (buf_rdata)
    );

    // Next-state logic for the sequencing FSM and its counters.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        rd_idx_d = rd_idx_q;
        to_cnt_d = to_cnt_q;
        mask_d   = mask_q;
        err_d    = err_q;
        buf_we   = 1'b0;
        buf_re   = 1'b0;
        cap_en   = '0;
        zero_en  = '0;
        unique case (state_q)
            FILL: begin
                if (in_xfer) begin
                    buf_we = 1'b1;
                    if (wr_cnt_q == InLast) begin
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        state_d  = BCAST;
                    end else begin
                        wr_cnt_d = wr_cnt_q + InCntW'(1);
                    end
                end
            end
            BCAST: begin
                if (rd_cnt_q != InEnd) begin
                    buf_re   = 1'b1;
                    rd_cnt_d = rd_cnt_q + InCntW'(1);
                end
                // Last beat is on the wire and nothing is left in the read pipe.
                if (nrn_vld_q && !rd_vld_q && (rd_cnt_q == InEnd)) begin
                    state_d  = WAIT;
                    mask_d   = '0;
                    to_cnt_d = '0;
                end
            end
            WAIT: begin
                cap_en = nrn_out_valid & ~mask_q;
                mask_d = mask_q | nrn_out_valid;
                if (&mask_d) begin
                    state_d = DRAIN;
                end else if (to_cnt_q == ToLast) begin
                    err_d   = 1'b1;
                    zero_en = ~mask_d;
                    state_d = DRAIN;
                end else begin
                    to_cnt_d = to_cnt_q + ToCntW'(1);
                end
            end
            DRAIN: begin
                if (out_xfer) begin
                    if (rd_idx_q == NrnLast) begin
                        rd_idx_d = '0;
                        state_d  = FILL;
                    end else begin
                        rd_idx_d = rd_idx_q + NrnCntW'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State, counters and broadcast pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FILL;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_idx_q   <= '0;
            to_cnt_q   <= '0;
            mask_q     <= '0;
            err_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            nrn_vld_q  <= 1'b0;
            nrn_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_idx_q   <= rd_idx_d;
            to_cnt_q   <= to_cnt_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
            rd_vld_q   <= buf_re;
            nrn_vld_q  <= rd_vld_q;
            nrn_data_q <= rd_vld_q ? buf_rdata : '0;
        end
    end

    // Activation capture; timed-out neurons read back as zero.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (cap_en[k]) begin
                out_buf_q[k] <= nrn_out_data[k*DATA_WIDTH +: DATA_WIDTH];
            end else if (zero_en[k]) begin
                out_buf_q[k] <= '0;
            end
        end
    end

    // Select the activation addressed by the drain index.
    always_comb begin
        out_sel = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (rd_idx_q == NrnCntW'(k)) begin
                out_sel = out_buf_q[k];
            end
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomised, self-checking bench for layer_sequencer (4 inputs, 3 neurons).
module tb_layer_sequencer;

    localparam int NI = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int TO = 8;
    localparam int NEVER = 99;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     nrn_in_data;
    logic              nrn_in_valid;
    logic [NN*DW-1:0]  nrn_out_data = '0;
    logic [NN-1:0]     nrn_out_valid = '0;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              busy;
    logic              err_timeout;

    layer_sequencer #(
        .NUM_INPUTS     (NI),
        .NUM_NEURONS    (NN),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .nrn_in_data   (nrn_in_data),
        .nrn_in_valid  (nrn_in_valid),
        .nrn_out_data  (nrn_out_data),
        .nrn_out_valid (nrn_out_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scenario description and observations.
    logic [DW-1:0] vec [NI];
    int            pul_at [NN];
    int            rep_at [NN];
    logic [DW-1:0] pul_val [NN];
    logic [DW-1:0] exp_out [NN];
    logic [DW-1:0] got_data [NN];
    logic          got_last [NN];
    int            got_n, first_ov, stall_changes;
    logic [DW-1:0] bq [$];
    int            runs = 0;
    logic          prev_v = 1'b0;
    int            bp_viol = 0;

    // Broadcast monitor: collects beats and counts separate valid runs.
    always @(negedge clk) begin
        if (rst && nrn_in_valid) begin
            bq.push_back(nrn_in_data);
            if (!prev_v) runs++;
        end
        prev_v = nrn_in_valid;
        if (busy && in_ready) bp_viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vector(input int start, input bit gappy);
        int i = start;
        int guard = 0;
        bit x;
        while (i < NI && guard < 100) begin
            in_data  = vec[i];
            in_valid = gappy ? (guard % 2 == 0) : 1'b1;
            x = in_valid && in_ready;
            step();
            if (x) i++;
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (i != NI) begin
            errors++;
            $display("FAIL push: accepted %0d words, required %0d", i, NI);
        end
    endtask

    task automatic wait_bcast_done();
        bit seen = 0;
        int n = 0;
        while (n < 40) begin
            if (nrn_in_valid) seen = 1;
            else if (seen) break;
            step();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL bcast_end: burst not finished, got seen=%0d required 1", seen);
        end
    endtask

    // Drives the neuron pulse schedule while draining the result.
    task automatic run_wait_drain(input int stall_at, input int stall_len, input bit rnd);
        logic [NN-1:0]    nv;
        logic [NN*DW-1:0] nd;
        logic [DW-1:0]    pd = '0;
        bit               pend = 0;
        got_n = 0;
        first_ov = -1;
        stall_changes = 0;
        for (int c = 0; c < 80 && got_n < NN; c++) begin
            nv = '0;
            for (int k = 0; k < NN; k++) begin
                if (c == pul_at[k]) begin
                    nv[k] = 1'b1;
                    nd[k*DW +: DW] = pul_val[k];
                end else if (c == rep_at[k]) begin
                    nv[k] = 1'b1;
                    nd[k*DW +: DW] = 16'hFFFF;
                end else begin
                    nd[k*DW +: DW] = 16'($urandom);
                end
            end
            nrn_out_valid = nv;
            nrn_out_data  = nd;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : !(c >= stall_at && c < stall_at + stall_len);
            if (out_valid && first_ov < 0) first_ov = c;
            if (pend && out_data !== pd) stall_changes++;
            if (out_valid && out_ready) begin
                got_data[got_n] = out_data;
                got_last[got_n] = out_last;
                got_n++;
                pend = 0;
            end else begin
                pend = out_valid;
                pd   = out_data;
            end
            step();
        end
        nrn_out_valid = '0;
        out_ready = 1'b0;
        checks++;
        if (got_n != NN) begin
            errors++;
            $display("FAIL drain_count: got %0d words, required %0d", got_n, NN);
        end
    endtask

    task automatic set_pulses(input int p0, input int p1, input int p2);
        pul_at[0] = p0; pul_at[1] = p1; pul_at[2] = p2;
        for (int k = 0; k < NN; k++) begin
            rep_at[k]  = NEVER;
            pul_val[k] = 16'h0A0A + 16'(k * 16'h0101);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        checks++;
        if ({busy, nrn_in_valid, out_valid, out_last, err_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000",
                     {busy, nrn_in_valid, out_valid, out_last, err_timeout});
        end
        checks++;
        if (nrn_in_data !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h required 0000/0000", nrn_in_data, out_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_normal();
        logic [6:0] hist;
        for (int i = 0; i < NI; i++) vec[i] = 16'(i + 1);
        bq.delete(); runs = 0;
        push_vector(0, 0);
        for (int t = 0; t < 7; t++) begin
            hist[t] = nrn_in_valid;
            if (t < 6) step();
        end
        checks++;
        if (hist !== 7'b0111100) begin
            errors++; $display("FAIL bcast_timing: got %b required 0111100", hist);
        end
        checks++;
        if (bq.size() != NI || runs != 1) begin
            errors++; $display("FAIL bcast_shape: got %0d beats/%0d runs required 4/1", bq.size(), runs);
        end
        for (int i = 0; i < NI && i < bq.size(); i++) begin
            checks++;
            if (bq[i] !== vec[i]) begin
                errors++; $display("FAIL bcast_data[%0d]: got %h required %h", i, bq[i], vec[i]);
            end
        end
        set_pulses(1, 2, 0);
        run_wait_drain(0, 0, 0);
        for (int k = 0; k < NN; k++) begin
            checks++;
            if (got_data[k] !== pul_val[k] || got_last[k] !== (k == NN - 1)) begin
                errors++;
                $display("FAIL normal_out[%0d]: got %h last=%b required %h last=%b",
                         k, got_data[k], got_last[k], pul_val[k], k == NN - 1);
            end
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL normal_ret_fill: got ready=%b busy=%b required 1/0", in_ready, busy);
        end
    endtask

    task automatic test_gaps_stall();
        for (int i = 0; i < NI; i++) vec[i] = 16'h1100 + 16'(i);
        bq.delete(); runs = 0;
        push_vector(0, 1);
        wait_bcast_done();
        checks++;
        if (bq.size() != NI || runs != 1) begin
            errors++; $display("FAIL gap_bcast_shape: got %0d beats/%0d runs required 4/1", bq.size(), runs);
        end
        for (int i = 0; i < NI && i < bq.size(); i++) begin
            checks++;
            if (bq[i] !== vec[i]) begin
                errors++; $display("FAIL gap_bcast_data[%0d]: got %h required %h", i, bq[i], vec[i]);
            end
        end
        set_pulses(0, 1, 2);
        run_wait_drain(4, 5, 0);
        checks++;
        if (stall_changes != 0) begin
            errors++; $display("FAIL stall_hold: got %0d changes required 0", stall_changes);
        end
        for (int k = 0; k < NN; k++) begin
            checks++;
            if (got_data[k] !== pul_val[k]) begin
                errors++; $display("FAIL stall_out[%0d]: got %h required %h", k, got_data[k], pul_val[k]);
            end
        end
    endtask

    task automatic test_simul_repeat();
        for (int i = 0; i < NI; i++) vec[i] = 16'(32 * i + 7);
        push_vector(0, 0);
        wait_bcast_done();
        set_pulses(0, 0, 0);
        rep_at[1] = 1;
        run_wait_drain(0, 0, 0);
        checks++;
        if (first_ov != 1) begin
            errors++; $display("FAIL simul_drain_cycle: got %0d required 1", first_ov);
        end
        checks++;
        if (got_data[1] !== pul_val[1]) begin
            errors++; $display("FAIL repeat_kept: got %h required %h", got_data[1], pul_val[1]);
        end
    endtask

    task automatic test_timeout();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL pre_timeout_err: got %b required 0", err_timeout);
        end
        for (int i = 0; i < NI; i++) vec[i] = 16'h5A00 + 16'(i);
        push_vector(0, 0);
        wait_bcast_done();
        set_pulses(0, 1, NEVER);
        run_wait_drain(0, 0, 0);
        checks++;
        if (first_ov != TO) begin
            errors++; $display("FAIL timeout_cycle: got %0d required %0d", first_ov, TO);
        end
        checks++;
        if (got_data[0] !== pul_val[0] || got_data[1] !== pul_val[1] || got_data[2] !== 16'h0000) begin
            errors++;
            $display("FAIL timeout_out: got %h %h %h required %h %h 0000",
                     got_data[0], got_data[1], got_data[2], pul_val[0], pul_val[1]);
        end
        step();
        checks++;
        if (err_timeout !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got err=%b ready=%b required 1/1", err_timeout, in_ready);
        end
    endtask

    task automatic test_reset_mid_bcast();
        for (int i = 0; i < NI; i++) vec[i] = 16'h7700 + 16'(i);
        push_vector(0, 0);
        step(); step(); step();
        rst = 1'b0;
        step();
        checks++;
        if (nrn_in_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got nv=%b busy=%b ready=%b err=%b required 0/0/0/0",
                     nrn_in_valid, busy, in_ready, err_timeout);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_release: got %b required 1", in_ready);
        end
        for (int i = 0; i < NI; i++) vec[i] = 16'h3300 + 16'(i);
        bq.delete(); runs = 0;
        push_vector(0, 0);
        wait_bcast_done();
        checks++;
        if (bq.size() != NI || bq[0] !== vec[0] || bq[NI-1] !== vec[NI-1]) begin
            errors++; $display("FAIL fresh_bcast: got %0d beats first=%h required 4 first=%h",
                               bq.size(), bq[0], vec[0]);
        end
        set_pulses(2, 0, 1);
        run_wait_drain(0, 0, 0);
        checks++;
        if (got_data[2] !== pul_val[2] || got_last[2] !== 1'b1) begin
            errors++; $display("FAIL fresh_out: got %h/%b required %h/1", got_data[2], got_last[2], pul_val[2]);
        end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < NI; i++) vec[i] = 16'(11 * (i + 1));
        bq.delete(); runs = 0;
        push_vector(0, 0);
        in_data = 16'hBEEF;
        in_valid = 1'b1;
        bp_viol = 0;
        wait_bcast_done();
        set_pulses(0, 0, 0);
        run_wait_drain(2, 3, 0);
        checks++;
        if (bp_viol != 0) begin
            errors++; $display("FAIL bp_ready: got %0d busy+ready cycles required 0", bp_viol);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (i >= bq.size() || bq[i] !== vec[i]) begin
                errors++; $display("FAIL bp_bcast[%0d]: got %h required %h", i, bq[i], vec[i]);
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_back: got %b required 1", in_ready);
        end
        step();
        vec[0] = 16'hBEEF; vec[1] = 16'h0055; vec[2] = 16'h0066; vec[3] = 16'h0077;
        bq.delete(); runs = 0;
        push_vector(1, 0);
        wait_bcast_done();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (i >= bq.size() || bq[i] !== vec[i]) begin
                errors++; $display("FAIL bp_addr0[%0d]: got %h required %h", i, bq[i], vec[i]);
            end
        end
        run_wait_drain(0, 0, 0);
    endtask

    task automatic test_random();
        bit exp_err = 0;
        for (int l = 0; l < 8; l++) begin
            bit timed = 0;
            int mx = 0;
            for (int i = 0; i < NI; i++) vec[i] = 16'($urandom);
            bq.delete(); runs = 0;
            push_vector(0, 1'($urandom_range(0, 1)));
            wait_bcast_done();
            for (int k = 0; k < NN; k++) begin
                pul_at[k]  = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 9));
                rep_at[k]  = pul_at[k] + int'($urandom_range(1, 3));
                pul_val[k] = 16'($urandom);
                // Model: a neuron counts only if it answers within the WAIT window.
                exp_out[k] = (pul_at[k] < TO) ? pul_val[k] : 16'h0000;
                if (pul_at[k] >= TO) timed = 1;
                else if (pul_at[k] > mx) mx = pul_at[k];
            end
            exp_err |= timed;
            run_wait_drain(0, 0, 1);
            checks++;
            if (bq.size() != NI || runs != 1 || bq[0] !== vec[0] || bq[NI-1] !== vec[NI-1]) begin
                errors++; $display("FAIL rnd_bcast[%0d]: got %0d beats/%0d runs required 4/1", l, bq.size(), runs);
            end
            checks++;
            if (first_ov != (timed ? TO : mx + 1)) begin
                errors++; $display("FAIL rnd_wait_len[%0d]: got %0d required %0d", l, first_ov, timed ? TO : mx + 1);
            end
            for (int k = 0; k < NN; k++) begin
                checks++;
                if (got_data[k] !== exp_out[k] || got_last[k] !== (k == NN - 1)) begin
                    errors++;
                    $display("FAIL rnd_out[%0d][%0d]: got %h last=%b required %h last=%b",
                             l, k, got_data[k], got_last[k], exp_out[k], k == NN - 1);
                end
            end
            checks++;
            if (stall_changes != 0 || err_timeout !== exp_err || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rnd_state[%0d]: got chg=%0d err=%b ready=%b required 0/%b/1",
                         l, stall_changes, err_timeout, in_ready, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_gaps_stall();
        test_simul_repeat();
        test_timeout();
        test_reset_mid_bcast();
        test_back_pressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Controller that sequences one fully connected layer of neuron instances.
- Buffers a complete input vector from upstream, then broadcasts it to every neuron in the layer as one gap-free burst.
- Collects each neuron's activation on that neuron's output-valid pulse, then streams the layer result downstream one value at a time.
- Sits between consecutive layers. It also guards against a neuron that never responds, using a timeout.

Parameters:
- NUM_INPUTS, 784, inputs per vector; equals each neuron's weight count.
- NUM_NEURONS, 30, neurons in the layer.
- DATA_WIDTH, 16, width of an input or activation word.
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before aborting.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_data  in  DATA_WIDTH  upstream input word.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept in_data.
- nrn_in_data  out  DATA_WIDTH  broadcast input to all neurons.
- nrn_in_valid  out  1  broadcast valid.
- nrn_out_data  in  NUM_NEURONS*DATA_WIDTH  neuron activations; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- nrn_out_valid  in  NUM_NEURONS  per-neuron one-cycle output-valid pulse.
- out_data  out  DATA_WIDTH  downstream activation word.
- out_valid  out  1  downstream word valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  marks the final word (index NUM_NEURONS-1).
- busy  out  1  high in any state other than FILL.
- err_timeout  out  1  sticky flag: a WAIT phase timed out.

Behaviour:
- Reset (rst=0 at a clock edge), from any state including mid-burst:
  - State goes to FILL; all counters and the capture mask are cleared.
  - in_ready=0 during reset, 1 in the first cycle after release.
  - nrn_in_valid, out_valid, out_last, busy and err_timeout are all 0.
  - nrn_in_data and out_data are 0.
  - Buffer contents are don't-care.
- A handshake transfer occurs when valid and ready are both high in the same cycle.
- FILL:
  - in_ready=1.
  - Each transfer writes in_data to input buffer address wr_cnt, and wr_cnt increments.
  - On the transfer with wr_cnt==NUM_INPUTS-1, go to BCAST. in_ready is 0 from the next cycle.
- BCAST:
  - rd_cnt runs 0..NUM_INPUTS-1, one address per cycle. The buffer has 1-cycle read latency; outputs are registered.
  - nrn_in_valid is high for exactly NUM_INPUTS consecutive cycles, starting 2 cycles after FILL exits.
  - nrn_in_data carries buffer[0..NUM_INPUTS-1] in order. There are no gaps, which the neurons require for end-of-burst detection.
  - Go to WAIT the cycle after the last valid beat. Clear capture_mask and the timeout counter.
- WAIT:
  - When nrn_out_valid[k]=1 and capture_mask[k]=0: capture the slice for neuron k into out_buf[k] and set capture_mask[k].
  - Repeat pulses for an already-captured neuron are ignored; the first value is kept.
  - Simultaneous pulses from several neurons are all captured in the same cycle.
  - When the mask is all ones (including pulses captured this cycle), go to DRAIN next cycle.
  - The timeout counter increments every WAIT cycle. If it reaches TIMEOUT_CYCLES-1 with the mask incomplete:
    - set err_timeout;
    - zero out_buf for every uncaptured neuron;
    - go to DRAIN.
  - nrn_out_valid is ignored in every state except WAIT.
- DRAIN:
  - out_valid=1 and out_data=out_buf[rd_idx], with rd_idx starting at 0.
  - out_data is held stable until a transfer occurs.
  - out_last=1 when rd_idx==NUM_NEURONS-1.
  - On the transfer of the last word, return to FILL. in_ready is 1 on the next cycle.
- In any non-FILL state in_ready=0; upstream data is back-pressured, not dropped.
- err_timeout is cleared only by reset.
- Widths: counter widths are $clog2(PARAM+1); no arithmetic is performed on data.
- Minimum layer turnaround: NUM_INPUTS (fill) + NUM_INPUTS+2 (broadcast) + neuron latency + NUM_NEURONS (drain) cycles.

Decomposition:
- Package layer_seq_pkg contains:
  - typedef enum logic [1:0] seq_state_t {FILL, BCAST, WAIT, DRAIN};
  - localparam widths derived from the block parameters.
- Sub-module seq_buf: simple dual-port RAM with synchronous write and registered 1-cycle read; depth NUM_INPUTS, width DATA_WIDTH. Used as the input buffer.
- out_buf is a register array inside layer_sequencer.

Test Plan (NUM_INPUTS=4, NUM_NEURONS=3, TIMEOUT_CYCLES=8, behavioural neuron model):
- Normal flow: push 0x0001..0x0004 with out_ready=1; neurons pulse in order k=2,0,1 with values 0x0A0A,0x0B0B,0x0C0C.
  -> nrn_in_valid high 4 consecutive cycles carrying 1,2,3,4.
  -> out_data sequence 0x0A0A, 0x0B0B, 0x0C0C with out_last on the 3rd word.
- Upstream gaps plus downstream stall: in_valid toggles every other cycle; out_ready low for 5 cycles mid-drain.
  -> broadcast is still gap-free; out_data is held stable during the stall; no word is lost or duplicated.
- Simultaneous and repeated pulses: all 3 neurons pulse in the same cycle, then neuron 1 pulses again with 0xFFFF.
  -> next cycle is DRAIN; out_buf[1] keeps its first value.
- Timeout: neuron 2 never pulses.
  -> after 8 WAIT cycles err_timeout=1; third output word is 0x0000; block returns to FILL; err_timeout stays 1.
- Reset mid-BCAST: rst=0 for one cycle after 2 broadcast beats.
  -> nrn_in_valid=0 and busy=0 next cycle; in_ready=1 after release; a fresh vector then completes normally.
- Back-pressure: hold in_valid=1 during BCAST/WAIT/DRAIN.
  -> in_ready=0 throughout; the first beat after returning to FILL is written at address 0.
